// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//   Shares one AXI4 read channel between NUM_PORTS internal requesters
//   (command fetch, TMU0, TMU1, framebuffer readback).
//   AR side: round-robin arbitration. The winning request is registered onto
//   m_axi_ar* with the port index placed in the upper ID bits.
//   R side: a purely combinational router keyed on m_axi_rid.
//
// Ports:
//   aclk, resetn        clock; asynchronous active-low reset
//   s_axi_ar*           per-port read address requests, port p at slice p
//   s_axi_r*            per-port read data returns (rdata/rresp/rlast broadcast)
//   m_axi_ar*           registered master read address channel
//   m_axi_r*            master read data channel
//
// Optional feature macro: AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN
//   When defined, each port is limited to MAX_OUTSTANDING bursts in flight.
module axi_read_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int PORT_BITS      = $clog2(NUM_PORTS),
  localparam int S_ID_WIDTH     = ID_WIDTH - PORT_BITS
) (
  input  logic                            aclk,
  input  logic                            resetn,
  input  logic [NUM_PORTS*S_ID_WIDTH-1:0] s_axi_arid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [NUM_PORTS*8-1:0]          s_axi_arlen,
  input  logic [NUM_PORTS*3-1:0]          s_axi_arsize,
  input  logic [NUM_PORTS*2-1:0]          s_axi_arburst,
  input  logic [NUM_PORTS-1:0]            s_axi_arvalid,
  output logic [NUM_PORTS-1:0]            s_axi_arready,
  output logic [NUM_PORTS*S_ID_WIDTH-1:0] s_axi_rid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] s_axi_rdata,
  output logic [NUM_PORTS*2-1:0]          s_axi_rresp,
  output logic [NUM_PORTS-1:0]            s_axi_rlast,
  output logic [NUM_PORTS-1:0]            s_axi_rvalid,
  input  logic [NUM_PORTS-1:0]            s_axi_rready,
  output logic [ID_WIDTH-1:0]             m_axi_arid,
  output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arlock,
  output logic [3:0]                      m_axi_arcache,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [ID_WIDTH-1:0]             m_axi_rid,
  input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  if (NUM_PORTS < 2 || NUM_PORTS > 4 || MAX_OUTSTANDING < 1) begin : g_bad_params
    $error("axi_read_arbiter: NUM_PORTS must be 2..4 and MAX_OUTSTANDING >= 1");
  end

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state, state_nxt;
  logic [PORT_BITS-1:0]   last_grant;
  logic [PORT_BITS-1:0]   winner;
  logic [PORT_BITS-1:0]   cand;
  logic                   win_valid;
  logic [NUM_PORTS-1:0]   eligible;
  logic                   grant;

  // R router select and validity
  logic [PORT_BITS-1:0]   sel;
  logic                   mapped;

  assign sel    = m_axi_rid[ID_WIDTH-1 -: PORT_BITS];
  assign mapped = (32'(sel) < NUM_PORTS);

`ifdef AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0]     outstanding [NUM_PORTS];
  logic [NUM_PORTS-1:0] cnt_inc, cnt_dec;
  logic [PORT_BITS-1:0] ar_port;

  assign ar_port = m_axi_arid[ID_WIDTH-1 -: PORT_BITS];

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      cnt_inc[p]  = m_axi_arvalid && m_axi_arready && (ar_port == PORT_BITS'(p));
      cnt_dec[p]  = m_axi_rvalid && m_axi_rready && m_axi_rlast && mapped &&
                    (sel == PORT_BITS'(p));
      eligible[p] = s_axi_arvalid[p] && (outstanding[p] != CNT_W'(MAX_OUTSTANDING));
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) outstanding[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (cnt_inc[p] && !cnt_dec[p])      outstanding[p] <= outstanding[p] + 1'b1;
        else if (cnt_dec[p] && !cnt_inc[p]) outstanding[p] <= outstanding[p] - 1'b1;
      end
    end
  end
`else
  assign eligible = s_axi_arvalid;
`endif

  // Round-robin search upward from last_grant+1, wrapping at NUM_PORTS-1.
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = PORT_BITS'((32'(last_grant) + i) % NUM_PORTS);
      if (!win_valid && eligible[cand]) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Gated on resetn so no requester sees a handshake while reset is held.
  assign grant = (state == IDLE) && win_valid && resetn;

  always_comb begin
    state_nxt     = state;
    s_axi_arready = '0;
    case (state)
      IDLE: begin
        if (grant) begin
          s_axi_arready[winner] = 1'b1;
          state_nxt             = ISSUE;
        end
      end
      ISSUE: begin
        if (m_axi_arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      last_grant    <= PORT_BITS'(NUM_PORTS - 1);
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant    <= winner;
        m_axi_arid    <= {winner, s_axi_arid[winner*S_ID_WIDTH +: S_ID_WIDTH]};
        m_axi_araddr  <= s_axi_araddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_arlen   <= s_axi_arlen[winner*8 +: 8];
        m_axi_arsize  <= s_axi_arsize[winner*3 +: 3];
        m_axi_arburst <= s_axi_arburst[winner*2 +: 2];
      end
    end
  end

  assign m_axi_arvalid = (state == ISSUE);
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = '0;
  assign m_axi_arprot  = '0;

  // R router: unmapped IDs are accepted and dropped so the channel never stalls.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++)
      s_axi_rvalid[p] = m_axi_rvalid && mapped && (sel == PORT_BITS'(p));
    m_axi_rready = mapped ? s_axi_rready[sel] : 1'b1;
  end

  assign s_axi_rid   = {NUM_PORTS{m_axi_rid[S_ID_WIDTH-1:0]}};
  assign s_axi_rdata = {NUM_PORTS{m_axi_rdata}};
  assign s_axi_rresp = {NUM_PORTS{m_axi_rresp}};
  assign s_axi_rlast = {NUM_PORTS{m_axi_rlast}};

endmodule
